// File: rtl/voice_mixer.sv
// voice_mixer: time-multiplexed stereo mixer feeding the I2S transmitter.
// On each sample_tick it walks every voice over a req/ack handshake and multiplies
// each sample by its left/right pan gain into wide signed accumulators. It then
// shifts the sums back to the sample scale, saturates them to BITWIDTH and holds
// the result until the next frame.
// Optional feature: define VOICE_MIXER_MASTER_VOL_EN to add the master_vol input
// and a VOL stage that applies a master gain between the shift and the clamp.
module voice_mixer #(
    parameter int unsigned BITWIDTH   = 24,
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned VOICE_W    = 24,
    parameter int unsigned GAIN_W     = 8,
    localparam int unsigned SEL_W     = $clog2(NUM_VOICES)
) (
    input  logic                ctl_clk,
    input  logic                ctl_rst,
    input  logic                sample_tick,
    output logic                voice_req,
    output logic [SEL_W-1:0]    voice_sel,
    input  logic                voice_ack,
    input  logic [VOICE_W-1:0]  voice_data,
    input  logic [GAIN_W-1:0]   voice_gain_l,
    input  logic [GAIN_W-1:0]   voice_gain_r,
`ifdef VOICE_MIXER_MASTER_VOL_EN
    input  logic [GAIN_W-1:0]   master_vol,
`endif
    output logic [BITWIDTH-1:0] wave_out_l,
    output logic [BITWIDTH-1:0] wave_out_r,
    output logic                wave_valid,
    output logic                clip_l,
    output logic                clip_r,
    output logic                busy,
    output logic                overrun,
    input  logic                ovr_clr
);

    localparam int unsigned ACC_W = VOICE_W + GAIN_W + SEL_W + 1;
`ifdef VOICE_MIXER_MASTER_VOL_EN
    localparam int unsigned CLAMP_W = ACC_W + GAIN_W + 1;
`else
    localparam int unsigned CLAMP_W = ACC_W;
`endif

`ifdef VOICE_MIXER_MASTER_VOL_EN
    typedef enum logic [2:0] {StIdle, StReq, StMac, StSat, StVol, StOut} state_t;
`else
    typedef enum logic [2:0] {StIdle, StReq, StMac, StSat, StOut} state_t;
`endif

    state_t r_state;
    state_t w_state_next;

    logic signed [VOICE_W-1:0] r_data;
    logic [GAIN_W-1:0]         r_gain_l;
    logic [GAIN_W-1:0]         r_gain_r;
    logic signed [ACC_W-1:0]   r_acc_l;
    logic signed [ACC_W-1:0]   r_acc_r;
    logic [SEL_W-1:0]          r_sel;
    logic [BITWIDTH-1:0]       r_wave_l;
    logic [BITWIDTH-1:0]       r_wave_r;
    logic                      r_clip_l;
    logic                      r_clip_r;
    logic                      r_valid;
    logic                      r_overrun;

    logic signed [ACC_W-1:0]   w_data_ext;
    logic signed [ACC_W-1:0]   w_gl_ext;
    logic signed [ACC_W-1:0]   w_gr_ext;
    logic signed [ACC_W-1:0]   w_prod_l;
    logic signed [ACC_W-1:0]   w_prod_r;
    logic signed [ACC_W-1:0]   w_shift_l;
    logic signed [ACC_W-1:0]   w_shift_r;
    logic signed [CLAMP_W-1:0] w_pre_l;
    logic signed [CLAMP_W-1:0] w_pre_r;
    logic [BITWIDTH:0]         w_sat_l;
    logic [BITWIDTH:0]         w_sat_r;
    logic                      w_last;

    // Returns {clipped, value} after clamping v into the signed BITWIDTH range.
    function automatic logic [BITWIDTH:0] f_sat(input logic signed [CLAMP_W-1:0] v);
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        hi = '0;
        hi[BITWIDTH-2:0] = '1;
        lo = ~hi;
        if (v > hi) begin
            f_sat = {1'b1, hi[BITWIDTH-1:0]};
        end else if (v < lo) begin
            f_sat = {1'b1, lo[BITWIDTH-1:0]};
        end else begin
            f_sat = {1'b0, v[BITWIDTH-1:0]};
        end
    endfunction

    // Sample is sign-extended, gains zero-extended, so the product is exact in ACC_W.
    assign w_data_ext = ACC_W'(r_data);
    assign w_gl_ext   = ACC_W'(r_gain_l);
    assign w_gr_ext   = ACC_W'(r_gain_r);
    assign w_prod_l   = w_data_ext * w_gl_ext;
    assign w_prod_r   = w_data_ext * w_gr_ext;
    assign w_shift_l  = r_acc_l >>> GAIN_W;
    assign w_shift_r  = r_acc_r >>> GAIN_W;
    assign w_last     = (r_sel == SEL_W'(NUM_VOICES - 1));

`ifdef VOICE_MIXER_MASTER_VOL_EN
    logic signed [ACC_W-1:0]   r_shift_l;
    logic signed [ACC_W-1:0]   r_shift_r;
    logic signed [CLAMP_W-1:0] w_vol_ext;
    logic signed [CLAMP_W-1:0] w_vprod_l;
    logic signed [CLAMP_W-1:0] w_vprod_r;

    assign w_vol_ext = CLAMP_W'(master_vol);
    assign w_vprod_l = CLAMP_W'(r_shift_l) * w_vol_ext;
    assign w_vprod_r = CLAMP_W'(r_shift_r) * w_vol_ext;
    assign w_pre_l   = w_vprod_l >>> GAIN_W;
    assign w_pre_r   = w_vprod_r >>> GAIN_W;

    // Holds the shifted sums between SAT and VOL.
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            r_shift_l <= '0;
            r_shift_r <= '0;
        end else if (r_state == StSat) begin
            r_shift_l <= w_shift_l;
            r_shift_r <= w_shift_r;
        end
    end
`else
    assign w_pre_l = w_shift_l;
    assign w_pre_r = w_shift_r;
`endif

    assign w_sat_l = f_sat(w_pre_l);
    assign w_sat_r = f_sat(w_pre_r);

    // State register.
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one REQ/MAC pair per voice, then the output stages.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (sample_tick) w_state_next = StReq;
            StReq:   if (voice_ack) w_state_next = StMac;
            StMac:   w_state_next = w_last ? StSat : StReq;
`ifdef VOICE_MIXER_MASTER_VOL_EN
            StSat:   w_state_next = StVol;
            StVol:   w_state_next = StOut;
`else
            StSat:   w_state_next = StOut;
`endif
            StOut:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        voice_req = (r_state == StReq);
        busy      = (r_state != StIdle);
    end

    // Datapath: capture, accumulate and register the saturated result.
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            r_data   <= '0;
            r_gain_l <= '0;
            r_gain_r <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_sel    <= '0;
            r_wave_l <= '0;
            r_wave_r <= '0;
            r_clip_l <= 1'b0;
            r_clip_r <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (sample_tick) begin
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_sel   <= '0;
                    end
                end
                StReq: begin
                    if (voice_ack) begin
                        r_data   <= voice_data;
                        r_gain_l <= voice_gain_l;
                        r_gain_r <= voice_gain_r;
                    end
                end
                StMac: begin
                    r_acc_l <= r_acc_l + w_prod_l;
                    r_acc_r <= r_acc_r + w_prod_r;
                    // Selector parks on the last voice until the next frame start.
                    if (!w_last) r_sel <= r_sel + 1'b1;
                end
`ifdef VOICE_MIXER_MASTER_VOL_EN
                StVol: begin
`else
                StSat: begin
`endif
                    r_wave_l <= w_sat_l[BITWIDTH-1:0];
                    r_wave_r <= w_sat_r[BITWIDTH-1:0];
                    r_clip_l <= w_sat_l[BITWIDTH];
                    r_clip_r <= w_sat_r[BITWIDTH];
                end
                default: ;
            endcase
        end
    end

    // wave_valid is high exactly for the OUT cycle, aligned with the new result.
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= (w_state_next == StOut);
        end
    end

    // Sticky overrun: a tick while busy sets it and wins over a same-cycle clear.
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            r_overrun <= 1'b0;
        end else if (sample_tick && (r_state != StIdle)) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign voice_sel  = r_sel;
    assign wave_out_l = r_wave_l;
    assign wave_out_r = r_wave_r;
    assign wave_valid = r_valid;
    assign clip_l     = r_clip_l;
    assign clip_r     = r_clip_r;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer with four voices; expected mixes come from
// a plain-arithmetic model of the weighted sum, shift and clamp.
module tb_voice_mixer;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sample_tick = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        voice_req;
    logic [1:0]  voice_sel;
    logic        voice_ack;
    logic [23:0] voice_data;
    logic [7:0]  voice_gain_l;
    logic [7:0]  voice_gain_r;
    logic [23:0] wave_out_l;
    logic [23:0] wave_out_r;
    logic        wave_valid;
    logic        clip_l;
    logic        clip_r;
    logic        busy;
    logic        overrun;

    logic signed [23:0] v_data [NV];
    logic [7:0]         v_gl   [NV];
    logic [7:0]         v_gr   [NV];

    logic ack_tied = 1'b1;
    int   ack_delay = 0;
    int   wait_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Voice source: answers the current selector from the bench's voice table.
    assign voice_data   = v_data[voice_sel];
    assign voice_gain_l = v_gl[voice_sel];
    assign voice_gain_r = v_gr[voice_sel];
    assign voice_ack    = ack_tied | (voice_req && (wait_cnt >= ack_delay));

    // Counts cycles a request has been pending without an ack.
    always @(posedge clk) begin
        if (!voice_req || voice_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    voice_mixer #(
        .BITWIDTH   (24),
        .NUM_VOICES (NV),
        .VOICE_W    (24),
        .GAIN_W     (8)
    ) u_dut (
        .ctl_clk      (clk),
        .ctl_rst      (rst_n),
        .sample_tick  (sample_tick),
        .voice_req    (voice_req),
        .voice_sel    (voice_sel),
        .voice_ack    (voice_ack),
        .voice_data   (voice_data),
        .voice_gain_l (voice_gain_l),
        .voice_gain_r (voice_gain_r),
        .wave_out_l   (wave_out_l),
        .wave_out_r   (wave_out_r),
        .wave_valid   (wave_valid),
        .clip_l       (clip_l),
        .clip_r       (clip_r),
        .busy         (busy),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
    );

    function automatic void sat(input longint s, output logic [23:0] v, output logic c);
        if (s > 64'sd8388607) begin
            v = 24'h7FFFFF;
            c = 1'b1;
        end else if (s < -64'sd8388608) begin
            v = 24'h800000;
            c = 1'b1;
        end else begin
            v = s[23:0];
            c = 1'b0;
        end
    endfunction

    // Reference: sum(data*gain) / 2^8 (floor), then clamp to 24-bit signed.
    function automatic void model(output logic [23:0] el, output logic [23:0] er,
                                  output logic cl, output logic cr);
        longint sl = 0;
        longint sr = 0;
        for (int i = 0; i < NV; i++) begin
            sl += longint'(v_data[i]) * longint'(v_gl[i]);
            sr += longint'(v_data[i]) * longint'(v_gr[i]);
        end
        sl = sl >>> 8;
        sr = sr >>> 8;
        sat(sl, el, cl);
        sat(sr, er, cr);
    endfunction

    task automatic set_single(input logic [23:0] d0, input logic [7:0] gl, input logic [7:0] gr);
        for (int i = 0; i < NV; i++) begin
            v_data[i] = '0;
            v_gl[i]   = gl;
            v_gr[i]   = gr;
        end
        v_data[0] = d0;
    endtask

    task automatic set_random();
        logic [31:0] t;
        for (int i = 0; i < NV; i++) begin
            t = $urandom;
            v_data[i] = t[23:0];
            v_data[i] = v_data[i] >>> $urandom_range(0, 3);
            v_gl[i]   = 8'($urandom_range(0, 255));
            v_gr[i]   = 8'($urandom_range(0, 255));
        end
    endtask

    // Starts a frame (tick sampled at edge 0) and returns cycles until wave_valid.
    // Optional extra tick (with optional ovr_clr) sampled at edge tick2_at.
    task automatic run_frame(input int tick2_at, input logic clr2,
                             output int lat, output int sel_bad);
        int cyc;
        logic prev_req;
        logic [1:0] prev_sel;
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
        cyc = 0;
        lat = -1;
        sel_bad = 0;
        prev_req = voice_req;
        prev_sel = voice_sel;
        while (lat < 0 && cyc < 400) begin
            sample_tick = (tick2_at != 0) && (cyc + 1 == tick2_at);
            ovr_clr = sample_tick & clr2;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            sample_tick = 1'b0;
            ovr_clr = 1'b0;
            if (voice_req && prev_req && (voice_sel != prev_sel)) sel_bad++;
            prev_req = voice_req;
            prev_sel = voice_sel;
            if (wave_valid) lat = cyc;
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (wave_out_l !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_wave_l got %h want 000000", wave_out_l);
        end
        n_tests++;
        if (wave_out_r !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_wave_r got %h want 000000", wave_out_r);
        end
        n_tests++;
        if ({voice_req, busy, wave_valid, clip_l, clip_r, overrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000000",
                     {voice_req, busy, wave_valid, clip_l, clip_r, overrun});
        end
        n_tests++;
        if (voice_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_sel got %0d want 0", voice_sel);
        end
    endtask

    task automatic test_basic();
        int lat;
        int sb;
        ack_tied = 1'b1;
        set_single(24'h100000, 8'h80, 8'h80);
        run_frame(0, 1'b0, lat, sb);
        n_tests++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 9", lat);
        end
        n_tests++;
        if ({wave_out_l, wave_out_r} !== {24'h080000, 24'h080000}) begin
            n_fail++;
            $display("FAIL basic_wave got %h/%h want 080000/080000", wave_out_l, wave_out_r);
        end
        n_tests++;
        if ({clip_l, clip_r} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_clip got %b want 00", {clip_l, clip_r});
        end
        // Output must hold after the valid pulse even as voice data changes.
        set_random();
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (wave_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid_pulse got %b want 0", wave_valid);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if ({wave_out_l, wave_out_r} !== {24'h080000, 24'h080000}) begin
            n_fail++;
            $display("FAIL basic_hold got %h/%h want 080000/080000", wave_out_l, wave_out_r);
        end
    endtask

    task automatic test_pan();
        int lat;
        int sb;
        set_single(24'h400000, 8'hFF, 8'h00);
        run_frame(0, 1'b0, lat, sb);
        n_tests++;
        if ({wave_out_l, wave_out_r} !== {24'h3FC000, 24'h000000}) begin
            n_fail++;
            $display("FAIL pan_wave got %h/%h want 3fc000/000000", wave_out_l, wave_out_r);
        end
    endtask

    task automatic test_saturation();
        int lat;
        int sb;
        for (int i = 0; i < NV; i++) begin
            v_data[i] = 24'h7FFFFF;
            v_gl[i]   = 8'hFF;
            v_gr[i]   = 8'hFF;
        end
        run_frame(0, 1'b0, lat, sb);
        n_tests++;
        if ({wave_out_l, wave_out_r, clip_l, clip_r} !== {24'h7FFFFF, 24'h7FFFFF, 2'b11}) begin
            n_fail++;
            $display("FAIL sat_pos got %h/%h clip %b%b want 7fffff/7fffff clip 11",
                     wave_out_l, wave_out_r, clip_l, clip_r);
        end
        for (int i = 0; i < NV; i++) v_data[i] = 24'h800000;
        run_frame(0, 1'b0, lat, sb);
        n_tests++;
        if ({wave_out_l, wave_out_r, clip_l, clip_r} !== {24'h800000, 24'h800000, 2'b11}) begin
            n_fail++;
            $display("FAIL sat_neg got %h/%h clip %b%b want 800000/800000 clip 11",
                     wave_out_l, wave_out_r, clip_l, clip_r);
        end
    endtask

    task automatic test_wait_states();
        int lat;
        int sb;
        logic [23:0] el;
        logic [23:0] er;
        logic cl;
        logic cr;
        ack_tied = 1'b0;
        ack_delay = 3;
        set_random();
        model(el, er, cl, cr);
        run_frame(0, 1'b0, lat, sb);
        n_tests++;
        if (lat !== 21) begin
            n_fail++;
            $display("FAIL wait_latency got %0d want 21", lat);
        end
        n_tests++;
        if (sb !== 0) begin
            n_fail++;
            $display("FAIL wait_sel_stable got %0d changes want 0", sb);
        end
        n_tests++;
        if ({wave_out_l, wave_out_r, clip_l, clip_r} !== {el, er, cl, cr}) begin
            n_fail++;
            $display("FAIL wait_wave got %h/%h clip %b%b want %h/%h clip %b%b",
                     wave_out_l, wave_out_r, clip_l, clip_r, el, er, cl, cr);
        end
    endtask

    task automatic test_random();
        int lat;
        int sb;
        logic [23:0] el;
        logic [23:0] er;
        logic cl;
        logic cr;
        for (int f = 0; f < 8; f++) begin
            ack_tied = 1'b0;
            ack_delay = $urandom_range(0, 2);
            set_random();
            model(el, er, cl, cr);
            run_frame(0, 1'b0, lat, sb);
            n_tests++;
            if (lat !== 9 + 4 * ack_delay) begin
                n_fail++;
                $display("FAIL rand_latency frame %0d got %0d want %0d", f, lat, 9 + 4 * ack_delay);
            end
            n_tests++;
            if ({wave_out_l, wave_out_r, clip_l, clip_r} !== {el, er, cl, cr}) begin
                n_fail++;
                $display("FAIL rand_wave frame %0d got %h/%h clip %b%b want %h/%h clip %b%b",
                         f, wave_out_l, wave_out_r, clip_l, clip_r, el, er, cl, cr);
            end
        end
        ack_tied = 1'b1;
        ack_delay = 0;
    endtask

    task automatic test_overrun();
        int lat;
        int sb;
        logic [23:0] el;
        logic [23:0] er;
        logic cl;
        logic cr;
        ack_tied = 1'b1;
        set_random();
        model(el, er, cl, cr);
        run_frame(5, 1'b0, lat, sb);
        n_tests++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL ovr_no_restart latency got %0d want 9", lat);
        end
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set got %b want 1", overrun);
        end
        n_tests++;
        if ({wave_out_l, wave_out_r} !== {el, er}) begin
            n_fail++;
            $display("FAIL ovr_wave got %h/%h want %h/%h", wave_out_l, wave_out_r, el, er);
        end
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear got %b want 0", overrun);
        end
        run_frame(3, 1'b1, lat, sb);
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_wins got %b want 1", overrun);
        end
    endtask

    task automatic test_reset_midframe();
        int lat;
        int sb;
        int n;
        logic [23:0] el;
        logic [23:0] er;
        logic cl;
        logic cr;
        ack_tied = 1'b0;
        ack_delay = 2;
        set_random();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        n = 0;
        while (!(voice_req && voice_sel == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!(voice_req && voice_sel == 2'd2)) begin
            n_fail++;
            $display("FAIL rstmid_reach_voice2 got req %b sel %0d want req 1 sel 2",
                     voice_req, voice_sel);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({wave_out_l, wave_out_r} !== 48'h0) begin
            n_fail++;
            $display("FAIL rstmid_wave got %h/%h want 0/0", wave_out_l, wave_out_r);
        end
        n_tests++;
        if ({voice_req, busy, wave_valid, clip_l, clip_r, overrun, voice_sel} !== 8'b0) begin
            n_fail++;
            $display("FAIL rstmid_flags got %b want 00000000",
                     {voice_req, busy, wave_valid, clip_l, clip_r, overrun, voice_sel});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (wave_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_no_valid cycle %0d got %b want 0", i, wave_valid);
            end
        end
        rst_n = 1'b1;
        ack_delay = 0;
        set_random();
        model(el, er, cl, cr);
        run_frame(0, 1'b0, lat, sb);
        n_tests++;
        if (lat !== 9 || {wave_out_l, wave_out_r, clip_l, clip_r} !== {el, er, cl, cr}) begin
            n_fail++;
            $display("FAIL rstmid_after got lat %0d %h/%h clip %b%b want lat 9 %h/%h clip %b%b",
                     lat, wave_out_l, wave_out_r, clip_l, clip_r, el, er, cl, cr);
        end
        ack_tied = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NV; i++) begin
            v_data[i] = '0;
            v_gl[i]   = '0;
            v_gr[i]   = '0;
        end
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_pan();
        test_saturation();
        test_wait_states();
        test_random();
        test_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Time-multiplexed stereo mixer directly upstream of the I2S transmitter; produces its wave_in_l/wave_in_r.
- On each frame strobe it walks all synth voices over a request/ack handshake.
- Each voice sample is scaled by a per-voice left/right pan gain and accumulated in a wide accumulator.
- Result is saturated to BITWIDTH and held stable until the next frame.

Parameters:
- BITWIDTH, 24, output sample width (two's complement); matches I2S transmitter BITWIDTH
- NUM_VOICES, 16, voices mixed per frame (2..64)
- VOICE_W, 24, signed voice sample width
- GAIN_W, 8, unsigned pan gain width; gain g scales by g/2^GAIN_W

Ports:
- ctl_clk  in  1  single block clock
- ctl_rst  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle frame strobe (one per audio frame)
- voice_req  out  1  request for sample of voice voice_sel
- voice_sel  out  CLOG2(NUM_VOICES)  voice index being requested
- voice_ack  in  1  voice_data/gains valid for voice_sel
- voice_data  in  VOICE_W  signed voice sample
- voice_gain_l  in  GAIN_W  left gain of voice_sel
- voice_gain_r  in  GAIN_W  right gain of voice_sel
- wave_out_l  out  BITWIDTH  mixed left sample (to i2s wave_in_l)
- wave_out_r  out  BITWIDTH  mixed right sample (to i2s wave_in_r)
- wave_valid  out  1  one-cycle pulse when wave_out_* update
- clip_l, clip_r  out  1 each  set if the last frame saturated that channel
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: sample_tick arrived while busy
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset (async, ctl_rst=0): state IDLE, voice_sel=0, all outputs 0, accumulators 0. Asserting reset mid-frame aborts the frame; no wave_valid is produced; outputs read 0.
- Accumulator width: VOICE_W+GAIN_W+CLOG2(NUM_VOICES)+1, signed. Products are signed voice_data times zero-extended gain.
- States:
  - IDLE: on sample_tick, clear both accumulators, voice_sel=0, go to REQ.
  - REQ: voice_req=1, voice_sel stable. On voice_ack=1 in the same cycle, register data and both gains, then go to MAC. voice_req may be acked in the cycle it first asserts. voice_ack outside REQ is ignored.
  - MAC: acc_l += data*gain_l; acc_r += data*gain_r. If voice_sel==NUM_VOICES-1, go to SAT; else voice_sel+1 and go to REQ.
  - SAT: arithmetic shift each accumulator right by GAIN_W. Clamp to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]. Set clip_x if clamped. Go to OUT.
  - OUT: register wave_out_l/r and clip_l/r, pulse wave_valid for one cycle, go to IDLE.
- Latency with voice_ack tied high: sample_tick sampled at edge 0 → wave_valid high after edge 2*NUM_VOICES+1. Each ack wait cycle adds one cycle.
- wave_out_l/r change only in the wave_valid cycle and hold otherwise.
- sample_tick while busy: ignored (frame not restarted), overrun set. If ovr_clr and a new overrun occur in the same cycle, set wins.
- voice_sel wraps to 0 only at the next frame start.

Optional Feature:
- Macro VOICE_MIXER_MASTER_VOL_EN.
- Defined: adds input master_vol [GAIN_W-1:0] and a VOL state between SAT's shift and clamp. VOL does pre-clamp value*master_vol >>GAIN_W, then clamps. Latency +1 cycle. master_vol is sampled in VOL.
- Undefined: no port, no VOL state, latency as above.

Test Plan:
- Reset mid-frame (NUM_VOICES=4, assert ctl_rst during voice 2 REQ) → all outputs 0, voice_req 0, no wave_valid. A later tick mixes normally.
- NUM_VOICES=4, ack tied high, voice0 data 0x100000, gains 0x80/0x80, others data 0 → wave_out_l=wave_out_r=0x080000, wave_valid 9 cycles after tick edge, clip 0.
- Pan: voice0 0x400000, gain_l 0xFF, gain_r 0x00 → wave_out_l=0x3FC000, wave_out_r=0x000000.
- Saturation: all 4 voices 0x7FFFFF gain 0xFF → wave_out=0x7FFFFF, clip_l=clip_r=1. All 0x800000 → 0x800000, clips 1.
- Wait states: ack 3 cycles after each req → wave_valid at 9+12=21 cycles. voice_sel stable while voice_req high. Same result as the no-wait case.
- Overrun: second tick 5 cycles after first → overrun=1, first frame result unchanged, no restart. ovr_clr pulse → overrun=0. ovr_clr with simultaneous overrun → overrun stays 1.
